plot_writer: RTL and testbench

- Downstream stage for the screen-drawing engines (screen fill, circle). It consumes their per-cycle plot requests (x, y, colour, plot) and converts them into linear framebuffer writes.
- Clips off-screen coordinates and buffers accepted pixels in a small FIFO, so the framebuffer write port can apply backpressure.
- Reports dropped and clipped pixels for debug.

---
 rtl/vga_pkg.sv | 19 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/plot_writer.sv | 77 +++++++
 tb/tb_plot_writer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Screen geometry and framebuffer write types shared by the drawing engines
// (screen fill, circle) and the plot writer.
package vga_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int FB_ADDR_W = 15;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [2:0]           colour;
    } fb_wr_t;

    // Linear framebuffer address for an on-screen pixel.
    function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
        return FB_ADDR_W'(y) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; rdata presents the head entry (zero when empty).
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/plot_writer.sv
// Clips per-cycle plot requests, converts them to linear framebuffer writes and
// buffers them so the framebuffer port can stall; keeps clip/overflow debug stats.
module plot_writer
    import vga_pkg::*;
#(
    parameter int SCREEN_W_P = SCREEN_W,
    parameter int SCREEN_H_P = SCREEN_H,
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DEPTH      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_x,
    input  logic [6:0]        in_y,
    input  logic [2:0]        in_colour,
    input  logic              in_plot,
    output logic              in_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic [15:0]       clip_cnt,
    output logic              overflow,
    input  logic              stat_clr,
    output logic              busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]   addr;
    logic                accept;
    logic                clip;
    logic                drop;
    logic                push;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [ADDR_W+2:0]   fifo_head;

    assign addr   = ADDR_W'(in_y) * ADDR_W'(SCREEN_W_P) + ADDR_W'(in_x);
    assign accept = in_plot && in_ready;
    assign clip   = accept && ((32'(in_x) >= SCREEN_W_P) || (32'(in_y) >= SCREEN_H_P));
    assign push   = accept && !clip;
    assign drop   = in_plot && !in_ready;

    sync_fifo #(
        .WIDTH (ADDR_W + 3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({addr, in_colour}),
        .pop   (fb_ready),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_ready = !fifo_full;
    assign fb_we    = !fifo_empty;
    assign busy     = !fifo_empty;
    assign fb_addr  = fifo_head[ADDR_W+2:3];
    assign fb_data  = fifo_head[2:0];

    // A clear on the same edge as a clip or drop wins; the event is not recorded.
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            clip_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (clip && clip_cnt != 16'hFFFF) clip_cnt <= clip_cnt + 16'd1;
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_plot_writer.sv
// Directed bench for plot_writer: addressing, clipping, backpressure, overflow,
// stat clear and mid-stream reset.
module tb_plot_writer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_plot;
    logic        in_ready;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic [15:0] clip_cnt;
    logic        overflow;
    logic        stat_clr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    plot_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_colour (in_colour),
        .in_plot   (in_plot),
        .in_ready  (in_ready),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_we     (fb_we),
        .fb_ready  (fb_ready),
        .clip_cnt  (clip_cnt),
        .overflow  (overflow),
        .stat_clr  (stat_clr),
        .busy      (busy)
    );

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_plot(input int x, input int y, input int c);
        in_x      = 8'(x);
        in_y      = 7'(y);
        in_colour = 3'(c);
        in_plot   = 1'b1;
    endtask

    int corner_x [4] = '{0, 159, 0, 159};
    int corner_y [4] = '{0, 0, 119, 119};
    int corner_a [4] = '{0, 159, 19040, 19199};
    int clip_x   [3] = '{160, 5, 255};
    int clip_y   [3] = '{5, 120, 127};
    int q[$];

    initial begin
        rst_n = 1'b0; in_x = '0; in_y = '0; in_colour = '0; in_plot = 1'b0;
        fb_ready = 1'b1; stat_clr = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        chk("rst_we", fb_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_clip", clip_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_data", fb_data, 0);

        // single plot, one-cycle latency
        set_plot(3, 2, 5);
        tick;
        in_plot = 1'b0;
        chk("single_we", fb_we, 1);
        chk("single_addr", fb_addr, 323);
        chk("single_data", fb_data, 5);
        tick;
        chk("single_we_off", fb_we, 0);

        // corners back-to-back
        for (int i = 0; i < 4; i++) begin
            set_plot(corner_x[i], corner_y[i], i + 1);
            tick;
            chk("corner_we", fb_we, 1);
            chk("corner_addr", fb_addr, corner_a[i]);
            chk("corner_data", fb_data, i + 1);
        end
        in_plot = 1'b0;
        tick;
        chk("corner_we_off", fb_we, 0);
        chk("corner_clip", clip_cnt, 0);

        // clipped coordinates
        for (int i = 0; i < 3; i++) begin
            set_plot(clip_x[i], clip_y[i], 7);
            tick;
            chk("clip_we", fb_we, 0);
        end
        in_plot = 1'b0;
        chk("clip_cnt3", clip_cnt, 3);
        chk("clip_ovf", overflow, 0);

        // backpressure: 10 plots into an 8-deep FIFO
        fb_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_plot(i, 10, i % 8);
            chk("bp_ready", in_ready, (i < 8) ? 1 : 0);
            tick;
        end
        in_plot = 1'b0;
        chk("bp_ovf", overflow, 1);
        chk("bp_clip", clip_cnt, 3);
        fb_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("bp_we", fb_we, 1);
            chk("bp_addr", fb_addr, 1600 + k);
            chk("bp_data", fb_data, k);
            tick;
        end
        chk("bp_drained", fb_we, 0);

        // full FIFO, then drain while plots are held; model tracks occupancy
        fb_ready = 1'b0;
        q.delete();
        for (int k = 0; k < 8; k++) begin
            set_plot(k, 20, k);
            q.push_back((3200 + k) * 8 + k);
            tick;
        end
        chk("full_ready", in_ready, 0);
        fb_ready = 1'b1;
        begin
            int nj = 8;
            for (int cyc = 0; cyc < 24; cyc++) begin
                bit exp_ready;
                bit do_push;
                if (cyc < 12) set_plot(nj, 21, nj % 8);
                else in_plot = 1'b0;
                exp_ready = (q.size() != 8);
                chk("str_ready", in_ready, exp_ready);
                chk("str_we", fb_we, (q.size() != 0) ? 1 : 0);
                if (q.size() != 0) chk("str_head", int'({fb_addr, fb_data}), q[0]);
                do_push = in_plot && exp_ready;
                if (q.size() != 0) void'(q.pop_front());
                if (do_push) begin
                    q.push_back((21 * 160 + nj) * 8 + (nj % 8));
                    nj++;
                end
                tick;
            end
            chk("str_count", nj, 19);
        end
        chk("str_empty", fb_we, 0);

        // stat_clr beats a simultaneous clip
        chk("pre_clr_ovf", overflow, 1);
        chk("pre_clr_clip", clip_cnt, 3);
        set_plot(200, 5, 1);
        stat_clr = 1'b1;
        tick;
        stat_clr = 1'b0;
        chk("clr_clip", clip_cnt, 0);
        chk("clr_ovf", overflow, 0);
        tick;
        in_plot = 1'b0;
        chk("post_clr_clip", clip_cnt, 1);

        // reset with 5 entries buffered
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_plot(i, 30, 2);
            tick;
        end
        in_plot = 1'b0;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        fb_ready = 1'b1;
        chk("mrst_we", fb_we, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_clip", clip_cnt, 0);
        chk("mrst_ovf", overflow, 0);
        tick;
        chk("mrst_we2", fb_we, 0);
        set_plot(7, 7, 3);
        tick;
        in_plot = 1'b0;
        chk("after_we", fb_we, 1);
        chk("after_addr", fb_addr, 1127);
        chk("after_data", fb_data, 3);
        tick;
        chk("after_we_off", fb_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
